// File: rtl/h14tx_pkg.sv
// Shared types and constants for the HDMI 1.4 transmitter data-island path.
// Holds the period encoding used by the timing generator, the packet layout
// and the serial BCH step shared by the ECC generators.
package h14tx_pkg;

  typedef enum logic [2:0] {
    PeriodControl    = 3'd0,
    PeriodPreamble   = 3'd1,
    PeriodGuardBand  = 3'd2,
    PeriodDataIsland = 3'd3,
    PeriodVideo      = 3'd4
  } period_t;

  localparam int PacketSlotLen = 32;
  localparam int SlotCntWidth  = $clog2(PacketSlotLen);
  localparam int NumSubpackets = 4;
  localparam int HdrDataBits   = 24;
  localparam int SubDataBits   = 56;
  localparam int EccBits       = 8;

  localparam logic [EccBits-1:0] BchPoly = 8'h83;

  // Slot positions where each stream switches from data bits to ECC bits.
  // The subpacket streams carry two bits per cycle, so their ECC starts at
  // half the data length.
  localparam logic [SlotCntWidth-1:0] HdrEccStart = SlotCntWidth'(HdrDataBits);
  localparam logic [SlotCntWidth-1:0] SubEccStart = SlotCntWidth'(SubDataBits / 2);
  localparam logic [SlotCntWidth-1:0] SlotLast    = SlotCntWidth'(PacketSlotLen - 1);

  typedef struct packed {
    logic [NumSubpackets-1:0][SubDataBits-1:0] sub;
    logic [HdrDataBits-1:0]                    header;
  } packet_t;

  // One serial BCH step: feedback is data XOR the bit about to leave the LFSR.
  function automatic logic [EccBits-1:0] bch_step(input logic [EccBits-1:0] ecc,
                                                  input logic               d);
    logic fb;
    fb = d ^ ecc[0];
    return (ecc >> 1) ^ (fb ? BchPoly : {EccBits{1'b0}});
  endfunction

endpackage

// File: rtl/h14tx_bch_ecc.sv
// Serial BCH ECC generator for one packet stream.
// BitsPerCycle = 1 for the header stream, 2 for a subpacket stream (bit 0 of
// i_data is folded in first). i_clr restarts the LFSR from zero; when i_clr
// and i_en are both high the update starts from zero in the same cycle, so the
// first data bit of a slot is never lost.
module h14tx_bch_ecc
  import h14tx_pkg::*;
#(
  parameter int BitsPerCycle = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [BitsPerCycle-1:0] i_data,
  output logic [EccBits-1:0]      o_ecc
);

  if (BitsPerCycle < 1 || BitsPerCycle > 2) begin : g_bad_bits_per_cycle
    $error("h14tx_bch_ecc supports 1 or 2 bits per cycle");
  end

  logic [EccBits-1:0] r_ecc;
  logic [EccBits-1:0] w_base;
  logic [EccBits-1:0] w_next;

  // Fold this cycle's data bits into the LFSR, starting from zero on clear.
  always_comb begin
    w_base = i_clr ? {EccBits{1'b0}} : r_ecc;
    w_next = w_base;
    for (int b = 0; b < BitsPerCycle; b++) begin
      w_next = bch_step(w_next, i_data[b]);
    end
  end

  // LFSR state: advances on data bits, holds while ECC bits are being sent.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ecc <= '0;
    end else if (i_en) begin
      r_ecc <= w_next;
    end else if (i_clr) begin
      r_ecc <= '0;
    end
  end

  assign o_ecc = r_ecc;

endmodule

// File: rtl/h14tx_island_packetizer.sv
// Data-island payload stage: serialises one packet per 32-cycle slot into the
// TERC4 nibbles of channels 0..2, appending BCH ECC per stream, and fills slots
// with null packets when no packet is offered.
// Optional feature macro: H14TX_PKT_STATS_EN adds saturating counters of
// completed real and null packets (o_pkt_sent_cnt, o_null_cnt).
module h14tx_island_packetizer
  import h14tx_pkg::*;
#(
  parameter int StatsWidth = 16
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  period_t                                   i_period,
  input  logic                                      i_hsync,
  input  logic                                      i_vsync,
  input  logic                                      i_pkt_valid,
  output logic                                      o_pkt_ready,
  input  logic [HdrDataBits-1:0]                    i_pkt_header,
  input  logic [NumSubpackets-1:0][SubDataBits-1:0] i_pkt_sub,
  output period_t                                   o_period_q,
  output logic                                      o_hsync_q,
  output logic                                      o_vsync_q,
  output logic [3:0]                                o_terc4_ch0,
  output logic [3:0]                                o_terc4_ch1,
  output logic [3:0]                                o_terc4_ch2,
  output logic                                      o_err_trunc
`ifdef H14TX_PKT_STATS_EN
  ,
  output logic [StatsWidth-1:0]                     o_pkt_sent_cnt,
  output logic [StatsWidth-1:0]                     o_null_cnt
`endif
);

  if (StatsWidth < 1) begin : g_bad_stats_width
    $error("StatsWidth must be at least 1");
  end

  logic                                      w_island;
  logic                                      w_slot_start;
  logic                                      w_accept;
  packet_t                                   w_new_pkt;
  logic [SlotCntWidth-1:0]                   r_cnt;
  logic [HdrDataBits-1:0]                    r_hdr_sr;
  logic [NumSubpackets-1:0][SubDataBits-1:0] r_sub_sr;
  logic                                      r_slot_real;
  logic                                      r_prev_island;
  logic                                      w_hdr_data;
  logic                                      w_hdr_bit;
  logic [NumSubpackets-1:0][1:0]             w_sub_data;
  logic [NumSubpackets-1:0][1:0]             w_sub_bits;
  logic [EccBits-1:0]                        w_hdr_ecc;
  logic [NumSubpackets-1:0][EccBits-1:0]     w_sub_ecc;
  logic                                      w_ecc_clr;
  logic                                      w_hdr_ecc_en;
  logic                                      w_sub_ecc_en;
  logic [3:0]                                w_ch0;
  logic [3:0]                                w_ch1;
  logic [3:0]                                w_ch2;

  assign w_island     = (i_period == PeriodDataIsland);
  assign w_slot_start = w_island && (r_cnt == '0);
  assign o_pkt_ready  = i_rst_n && w_slot_start;
  assign w_accept     = o_pkt_ready && i_pkt_valid;

  // Packet for a starting slot: the offered one, or an all-zero null packet.
  always_comb begin
    w_new_pkt = '0;
    if (w_accept) begin
      w_new_pkt.header = i_pkt_header;
      w_new_pkt.sub    = i_pkt_sub;
    end
  end

  // Slot position: counts island cycles modulo 32, parked at 0 elsewhere.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_island) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Payload shift registers. Bit 0 of a new packet goes out straight from the
  // input in the slot's first cycle, so only the remaining bits are stored.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hdr_sr    <= '0;
      r_sub_sr    <= '0;
      r_slot_real <= 1'b0;
    end else if (w_slot_start) begin
      r_hdr_sr    <= w_new_pkt.header >> 1;
      for (int k = 0; k < NumSubpackets; k++) begin
        r_sub_sr[k] <= w_new_pkt.sub[k] >> 2;
      end
      r_slot_real <= w_accept;
    end else if (w_island) begin
      r_hdr_sr <= r_hdr_sr >> 1;
      for (int k = 0; k < NumSubpackets; k++) begin
        r_sub_sr[k] <= r_sub_sr[k] >> 2;
      end
    end
  end

  // Current data bits, then switch each stream to its ECC once data is done.
  always_comb begin
    w_hdr_data = (r_cnt == '0) ? w_new_pkt.header[0] : r_hdr_sr[0];
    w_hdr_bit  = (r_cnt < HdrEccStart) ? w_hdr_data : w_hdr_ecc[r_cnt[2:0]];
    for (int k = 0; k < NumSubpackets; k++) begin
      w_sub_data[k] = (r_cnt == '0) ? w_new_pkt.sub[k][1:0] : r_sub_sr[k][1:0];
      w_sub_bits[k] = (r_cnt < SubEccStart) ? w_sub_data[k]
                    : {w_sub_ecc[k][{r_cnt[1:0], 1'b1}], w_sub_ecc[k][{r_cnt[1:0], 1'b0}]};
    end
  end

  assign w_ecc_clr    = !w_island || (r_cnt == '0);
  assign w_hdr_ecc_en = w_island && (r_cnt < HdrEccStart);
  assign w_sub_ecc_en = w_island && (r_cnt < SubEccStart);

  h14tx_bch_ecc #(
    .BitsPerCycle(1)
  ) u_hdr_ecc (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_ecc_clr),
    .i_en   (w_hdr_ecc_en),
    .i_data (w_hdr_data),
    .o_ecc  (w_hdr_ecc)
  );

  for (genvar k = 0; k < NumSubpackets; k++) begin : g_sub_ecc
    h14tx_bch_ecc #(
      .BitsPerCycle(2)
    ) u_sub_ecc (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (w_ecc_clr),
      .i_en   (w_sub_ecc_en),
      .i_data (w_sub_data[k]),
      .o_ecc  (w_sub_ecc[k])
    );
  end

  // Assemble the three TERC4 nibbles; channel 0 bit 3 marks non-first cycles.
  always_comb begin
    w_ch0 = {r_prev_island, w_hdr_bit, i_vsync, i_hsync};
    w_ch1 = '0;
    w_ch2 = '0;
    for (int k = 0; k < NumSubpackets; k++) begin
      w_ch1[k] = w_sub_bits[k][0];
      w_ch2[k] = w_sub_bits[k][1];
    end
  end

  // Registered outputs: one cycle behind the timing generator inputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_period_q  <= PeriodControl;
      o_hsync_q   <= 1'b0;
      o_vsync_q   <= 1'b0;
      o_terc4_ch0 <= '0;
      o_terc4_ch1 <= '0;
      o_terc4_ch2 <= '0;
    end else begin
      o_period_q  <= i_period;
      o_hsync_q   <= i_hsync;
      o_vsync_q   <= i_vsync;
      o_terc4_ch0 <= w_island ? w_ch0 : 4'h0;
      o_terc4_ch1 <= w_island ? w_ch1 : 4'h0;
      o_terc4_ch2 <= w_island ? w_ch2 : 4'h0;
    end
  end

  // Remember whether the previous cycle was island; cleared so the first
  // island cycle after reset is also flagged as a first cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev_island <= 1'b0;
    end else begin
      r_prev_island <= w_island;
    end
  end

  // Sticky truncation flag: island left while a slot was still in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err_trunc <= 1'b0;
    end else if (!w_island && (r_cnt != '0)) begin
      o_err_trunc <= 1'b1;
    end
  end

`ifdef H14TX_PKT_STATS_EN
  logic                  w_slot_done;
  logic [StatsWidth-1:0] r_pkt_sent_cnt;
  logic [StatsWidth-1:0] r_null_cnt;

  assign w_slot_done = w_island && (r_cnt == SlotLast);

  // Saturating counts of slots that ran to completion, split by packet kind.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pkt_sent_cnt <= '0;
      r_null_cnt     <= '0;
    end else if (w_slot_done) begin
      if (r_slot_real) begin
        if (r_pkt_sent_cnt != {StatsWidth{1'b1}}) begin
          r_pkt_sent_cnt <= r_pkt_sent_cnt + 1'b1;
        end
      end else begin
        if (r_null_cnt != {StatsWidth{1'b1}}) begin
          r_null_cnt <= r_null_cnt + 1'b1;
        end
      end
    end
  end

  assign o_pkt_sent_cnt = r_pkt_sent_cnt;
  assign o_null_cnt     = r_null_cnt;
`endif

endmodule

// File: doc/h14tx_island_packetizer.md
# h14tx_island_packetizer

Data-island payload stage of the HDMI 1.4 transmitter, sitting directly downstream of the timing generator and upstream of the TERC4/TMDS channel encoders. It consumes `period`, `hsync` and `vsync` from the timing generator and accepts InfoFrame/audio packets over a valid/ready interface. For each island it serialises one packet per 32-cycle slot into per-channel TERC4 nibbles, computing BCH ECC on the fly, and fills empty slots with null packets.

## Interface
- `StatsWidth`, default 16: width of the optional statistics counters.
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset. One clock domain; reset is synchronous and active-low.
- `period`  in  `period_t`  current period from the timing generator. `PeriodDataIsland` marks island payload cycles; guard bands are excluded.
- `hsync`, `vsync`  in  1 each  sync levels from the timing generator.
- `pkt_valid`  in  1  packet offered.
- `pkt_ready`  out  1  packet accepted this cycle when `pkt_valid` is also high.
- `pkt_header`  in  24  header bytes HB0..HB2, LSB-first.
- `pkt_sub`  in  4×56  subpackets SB0..SB3 (7 bytes each), LSB-first.
- `period_q`  out  `period_t`  `period` delayed one cycle.
- `hsync_q`, `vsync_q`  out  1 each  sync levels delayed one cycle.
- `terc4_ch0`, `terc4_ch1`, `terc4_ch2`  out  4 each  TERC4 data nibbles; 0 outside island cycles.
- `err_trunc`  out  1  sticky flag: an island ended mid-packet.
- `pkt_sent_cnt`, `null_cnt`  out  `StatsWidth` each  present only under the configuration macro (see Configuration).

## Operation
- Slot counter `cnt` is 5 bits. It increments on every `PeriodDataIsland` cycle and wraps from 31 to 0. It is forced to 0 on any non-island cycle.
- `pkt_ready` is combinational: `period==PeriodDataIsland && cnt==0`.
  - On accept, the header and subpackets are latched into shift registers.
  - If `cnt==0` and `pkt_valid` is low, a null packet (all-zero header and subpackets) is latched instead.
  - A `pkt_valid` that is not accepted is held by the source; the block never drops it.
- Bit `i` of each slot, for `i = cnt`:
  - Header: bits 0..23 are data bits, bits 24..31 are the header ECC.
  - Each subpacket: bits 2i and 2i+1. Bits 0..55 are data, bits 56..63 are that subpacket's ECC.
- ECC uses a serial LFSR per stream (1 header + 4 subpackets), cleared at `cnt==0`. For each data bit `d`: `fb = d ^ ecc[0]`, then `ecc = (ecc>>1) ^ (fb ? 8'h83 : 0)`. Subpackets apply this step twice per cycle, bit 2i first. ECC bits are sent LSB-first.
- `terc4_ch0`:
  - bit0 = `hsync`, bit1 = `vsync`, bit2 = header bit.
  - bit3 = 0 only on the first cycle of an island (previous cycle not island, or first cycle after reset); 1 otherwise.
- `terc4_ch1[k]` = subpacket k, bit 2i. `terc4_ch2[k]` = subpacket k, bit 2i+1.
- Truncation: if `period` leaves island while `cnt!=0`, `err_trunc` is set and the partial packet is discarded. The next island starts a new slot.
- `err_trunc` clears only on reset.

## Timing
- All outputs except `pkt_ready` are registered, with 1-cycle latency from `period`, `hsync` and `vsync`. The nibble for `cnt==0` is derived from the inputs accepted in that same cycle.
- Reset values:
  - `terc4_*` = 0, `hsync_q` = `vsync_q` = 0, `period_q` = `PeriodControl`.
  - `err_trunc` = 0, `cnt` = 0, ECC = 0, counters = 0.
  - The "first cycle" flag is armed.
- Reset mid-island aborts the packet with no `err_trunc`. `pkt_ready` is low while `rst_n` is low.
- Back-to-back packets in one island are accepted every 32 cycles with no bubble.

## Configuration
- `H14TX_PKT_STATS_EN` defined:
  - `pkt_sent_cnt` counts completed (32-cycle) real packets.
  - `null_cnt` counts completed null packets.
  - Both are saturating at all-ones and cleared by reset.
- Macro undefined: both ports and their logic are absent.

## Structure
- `h14tx_pkg` holds:
  - `period_t` (already shared).
  - `PacketSlotLen = 32`.
  - `BchPoly = 8'h83`.
  - A `packet_t` struct (header plus 4 subpackets).
- One sub-module, `h14tx_bch_ecc`: serial LFSR parameterised on bits per cycle (1 or 2), with clear/enable inputs. It is instantiated 5 times.

## Test plan
- Island of 32 cycles, `pkt_valid` = 0 → null packet sent: `terc4_ch1`/`terc4_ch2` all 0; `terc4_ch0` = {bit3 = 0 then 1, 0, `vsync`, `hsync`}.
- `pkt_header` = 24'h000001, subpackets zero → header stream is 1, then 23 zeros, then ECC 8'h4A LSB-first.
- Random packets across 18-slot islands → bitstream and ECC match the golden model; `pkt_ready` pulses exactly at `cnt==0`.
- `pkt_valid` held across a non-island region → accepted on the first island cycle and never duplicated.
- Island of 40 cycles → second packet truncated, `err_trunc` = 1, next island's first nibble has bit3 = 0.
- With `H14TX_PKT_STATS_EN`: 3 real + 2 null slots → `pkt_sent_cnt` = 3, `null_cnt` = 2. Reset mid-island clears all outputs to the listed reset values.
